pw_rx_assembler: RTL and testbench

- Consumes the serialized pipelined-write bus: one 10-bit write_cmd_t beat followed by 1-4 write_data_t beats.
- Reassembles the beats into one 50-bit pipelined_write_t and presents it downstream through a valid/ready handshake with a 1-entry output buffer.
- Generates wdone pulses according to write_type.
- Flags protocol, overflow and stall-timeout errors.
- Sits directly downstream of the pipelined-write serializer and feeds the write-execution stage.

---
 rtl/pw_rx_assembler.sv | 253 +++++++++++++++++++++++++
 tb/tb_pw_rx_assembler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_rx_assembler.sv
// ---------------------------------------------------------------------------
// pw_rx_assembler
//
// Purpose:
//   Receives the serialized pipelined-write bus (one command beat followed by
//   1..MAX_WR_CYCLES data beats). It reassembles the beats into a single
//   pipelined_write_t word and hands that word downstream through a
//   valid/ready handshake backed by a 1-entry output buffer.
//   The block also generates write-done pulses according to write_type, and
//   flags protocol, buffer-overflow and stall-timeout errors.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   wr_bus       in   beat input, sampled every cycle, no backpressure
//                     cmd beat : vld[9] rsvd[8:5] num_cycles[4:3] write_type[2:0]
//                     data beat: cycle_type[9:8] dat[7:0]
//   pw_vld       out  assembled write valid
//   pw_rdy       in   downstream ready
//   pw_data      out  {cmd_cycle, dat0, dat1, dat2, dat3}; each data slot
//                     holds the full 10-bit beat, and unused slots are zero
//   wdone        out  write-done pulse (1 cycle)
//   err_proto    out  protocol-error pulse (1 cycle)
//   err_ovfl     out  output-buffer overflow pulse (1 cycle)
//   err_timeout  out  stall-timeout pulse (1 cycle)
// ---------------------------------------------------------------------------
module pw_rx_assembler #(
    parameter int MAX_WR_CYCLES = 4,
    parameter int WR_WIDTH      = 8,
    parameter int IDLE_TIMEOUT  = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [WR_WIDTH+1:0]                         wr_bus,
    output logic                                        pw_vld,
    input  logic                                        pw_rdy,
    output logic [(MAX_WR_CYCLES+1)*(WR_WIDTH+2)-1:0]   pw_data,
    output logic                                        wdone,
    output logic                                        err_proto,
    output logic                                        err_ovfl,
    output logic                                        err_timeout
);

    localparam int BEAT_W = WR_WIDTH + 2;
    localparam int PW_W   = (MAX_WR_CYCLES + 1) * BEAT_W;
    localparam int SLOT_W = (MAX_WR_CYCLES > 1) ? $clog2(MAX_WR_CYCLES) : 1;
    localparam int TMO_W  = $clog2(IDLE_TIMEOUT + 1);

    // cycle_type encodings of a data beat; the value 3 is illegal
    localparam logic [1:0] CT_IDLE  = 2'd0;
    localparam logic [1:0] CT_VALID = 2'd1;
    localparam logic [1:0] CT_DONE  = 2'd2;

    // write_type encodings; STD (0) needs no special handling, >2 is illegal
    localparam logic [2:0] WT_MULTI  = 3'd1;
    localparam logic [2:0] WT_SINGLE = 3'd2;

    typedef enum logic {
        ST_IDLE,
        ST_DATA
    } state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      cmd_q, cmd_d;
    logic [BEAT_W-1:0]      slot_q [MAX_WR_CYCLES];
    logic [BEAT_W-1:0]      slot_d [MAX_WR_CYCLES];
    logic [SLOT_W-1:0]      idx_q, idx_d;
    // index of the final data beat (expected beat count minus one)
    logic [SLOT_W-1:0]      last_q, last_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   pw_vld_q, pw_vld_d;
    logic [PW_W-1:0]        pw_data_q, pw_data_d;
    logic                   wdone_q, wdone_d;
    logic                   err_proto_q, err_proto_d;
    logic                   err_ovfl_q, err_ovfl_d;
    logic                   err_timeout_q, err_timeout_d;

    logic [1:0]             beat_type;
    logic [1:0]             cmd_num;
    logic [2:0]             cmd_wtype;
    logic [2:0]             buf_wtype;
    logic                   pop;
    logic                   buf_free;
    logic [SLOT_W-1:0]      num_last;

    assign beat_type = wr_bus[BEAT_W-1 -: 2];
    assign cmd_num   = wr_bus[4:3];
    assign cmd_wtype = wr_bus[2:0];
    assign buf_wtype = pw_data_q[PW_W-BEAT_W +: 3];
    assign pop       = pw_vld_q & pw_rdy;
    // A pop and a load in the same cycle is legal, so that write streams
    // keep flowing with no bubble between them.
    assign buf_free  = ~pw_vld_q | pw_rdy;

    // num_cycles == 0 encodes the maximum write length
    assign num_last  = (cmd_num == 2'd0) ? SLOT_W'(MAX_WR_CYCLES - 1)
                                         : SLOT_W'(cmd_num - 2'd1);

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        slot_d        = slot_q;
        idx_d         = idx_q;
        last_d        = last_q;
        tmo_d         = tmo_q;
        pw_vld_d      = pw_vld_q;
        pw_data_d     = pw_data_q;
        wdone_d       = 1'b0;
        err_proto_d   = 1'b0;
        err_ovfl_d    = 1'b0;
        err_timeout_d = 1'b0;

        // A SINGLE_WDONE write reports done once it has left the buffer.
        // pw_data is left unchanged on a pop.
        if (pop) begin
            pw_vld_d = 1'b0;
            if (buf_wtype == WT_SINGLE) begin
                wdone_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_bus[BEAT_W-1]) begin
                    if (cmd_wtype > WT_SINGLE) begin
                        err_proto_d = 1'b1;
                    end else begin
                        cmd_d   = wr_bus;
                        last_d  = num_last;
                        idx_d   = '0;
                        tmo_d   = '0;
                        for (int i = 0; i < MAX_WR_CYCLES; i++) begin
                            slot_d[i] = '0;
                        end
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                case (beat_type)
                    CT_IDLE: begin
                        // tmo_q counts the IDLE beats before this one, so
                        // this is the IDLE_TIMEOUT-th consecutive IDLE beat
                        if (tmo_q == TMO_W'(IDLE_TIMEOUT - 1)) begin
                            err_timeout_d = 1'b1;
                            tmo_d         = '0;
                            state_d       = ST_IDLE;
                        end else begin
                            tmo_d = tmo_q + 1'b1;
                        end
                    end

                    CT_VALID: begin
                        if (idx_q == last_q) begin
                            err_proto_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            slot_d[idx_q] = wr_bus;
                            idx_d         = idx_q + 1'b1;
                            tmo_d         = '0;
                            if (cmd_q[2:0] == WT_MULTI) begin
                                wdone_d = 1'b1;
                            end
                        end
                    end

                    CT_DONE: begin
                        if (idx_q != last_q) begin
                            err_proto_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            slot_d[idx_q] = wr_bus;
                            tmo_d         = '0;
                            state_d       = ST_IDLE;
                            if (buf_free) begin
                                pw_vld_d = 1'b1;
                                pw_data_d[PW_W-1 -: BEAT_W] = cmd_q;
                                for (int i = 0; i < MAX_WR_CYCLES; i++) begin
                                    pw_data_d[PW_W-1-(i+1)*BEAT_W -: BEAT_W] = slot_d[i];
                                end
                                if (cmd_q[2:0] == WT_MULTI) begin
                                    wdone_d = 1'b1;
                                end
                            end else begin
                                // The buffered write wins. The new write is
                                // lost, and so is its done pulse.
                                err_ovfl_d = 1'b1;
                            end
                        end
                    end

                    default: begin
                        err_proto_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                endcase
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q         <= '0;
            for (int i = 0; i < MAX_WR_CYCLES; i++) begin
                slot_q[i] <= '0;
            end
            idx_q         <= '0;
            last_q        <= '0;
            tmo_q         <= '0;
            pw_vld_q      <= 1'b0;
            pw_data_q     <= '0;
            wdone_q       <= 1'b0;
            err_proto_q   <= 1'b0;
            err_ovfl_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            cmd_q         <= cmd_d;
            for (int i = 0; i < MAX_WR_CYCLES; i++) begin
                slot_q[i] <= slot_d[i];
            end
            idx_q         <= idx_d;
            last_q        <= last_d;
            tmo_q         <= tmo_d;
            pw_vld_q      <= pw_vld_d;
            pw_data_q     <= pw_data_d;
            wdone_q       <= wdone_d;
            err_proto_q   <= err_proto_d;
            err_ovfl_q    <= err_ovfl_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign pw_vld      = pw_vld_q;
    assign pw_data     = pw_data_q;
    assign wdone       = wdone_q;
    assign err_proto   = err_proto_q;
    assign err_ovfl    = err_ovfl_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_pw_rx_assembler.sv
// ---------------------------------------------------------------------------
// tb_pw_rx_assembler
//
// Self-checking bench for pw_rx_assembler. A transaction-level reference
// model keeps each write in progress as a queue of received data beats and
// keeps the output buffer as a single slot. Every cycle, the DUT outputs are
// compared against the model. A table of complete writes checks the
// assembled word and the pulse counts. Hand-written sequences cover
// backpressure, overflow, timeout and reset.
// ---------------------------------------------------------------------------
module tb_pw_rx_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  wr_bus;
    logic        pw_vld;
    logic        pw_rdy;
    logic [49:0] pw_data;
    logic        wdone;
    logic        err_proto;
    logic        err_ovfl;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pw_rx_assembler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_bus      (wr_bus),
        .pw_vld      (pw_vld),
        .pw_rdy      (pw_rdy),
        .pw_data     (pw_data),
        .wdone       (wdone),
        .err_proto   (err_proto),
        .err_ovfl    (err_ovfl),
        .err_timeout (err_timeout)
    );

    // reference model state
    bit          mBusy;
    logic [9:0]  mCmd;
    logic [9:0]  mGot[$];
    int          mExp;
    int          mIdles;
    bit          mBufVld;
    logic [49:0] mBufData;
    bit          eWdone, eProto, eOvfl, eTmo;

    // observations accumulated for the table checks
    bit          seenVld;
    logic [49:0] seenData;
    int          wdoneCnt, protoCnt, ovflCnt, tmoCnt;

    typedef struct packed {
        logic [9:0]       cmd;
        logic [0:7][9:0]  beats;
        int               nb;
        bit               expVld;
        logic [49:0]      expData;
        int               expWdone;
        int               expProto;
    } vec_t;

    vec_t vecs [9];

    task automatic modelReset();
        mBusy    = 1'b0;
        mCmd     = '0;
        mGot.delete();
        mExp     = 0;
        mIdles   = 0;
        mBufVld  = 1'b0;
        mBufData = '0;
        eWdone   = 1'b0;
        eProto   = 1'b0;
        eOvfl    = 1'b0;
        eTmo     = 1'b0;
    endtask

    // Given the beat and the ready value seen in this cycle, work out the
    // outputs expected in the next cycle.
    task automatic modelStep(input logic [9:0] beat, input bit rdy);
        logic [1:0]  ct;
        bit          isLast;
        logic [49:0] word;
        eWdone = 1'b0;
        eProto = 1'b0;
        eOvfl  = 1'b0;
        eTmo   = 1'b0;
        if (mBufVld && rdy) begin
            mBufVld = 1'b0;
            if (mBufData[42:40] == 3'd2) eWdone = 1'b1;
        end
        if (!mBusy) begin
            if (beat[9]) begin
                if (beat[2:0] > 3'd2) begin
                    eProto = 1'b1;
                end else begin
                    mBusy  = 1'b1;
                    mCmd   = beat;
                    mExp   = (beat[4:3] == 2'd0) ? 4 : int'(beat[4:3]);
                    mGot.delete();
                    mIdles = 0;
                end
            end
        end else begin
            ct     = beat[9:8];
            isLast = (mGot.size() == mExp - 1);
            if (ct == 2'd0) begin
                mIdles++;
                if (mIdles == 16) begin
                    eTmo  = 1'b1;
                    mBusy = 1'b0;
                end
            end else if (ct == 2'd3 || (ct == 2'd1 && isLast) || (ct == 2'd2 && !isLast)) begin
                eProto = 1'b1;
                mBusy  = 1'b0;
            end else begin
                mGot.push_back(beat);
                mIdles = 0;
                if (ct == 2'd2) begin
                    mBusy = 1'b0;
                    if (mBufVld) begin
                        eOvfl = 1'b1;
                    end else begin
                        word = {mCmd, 40'd0};
                        for (int i = 0; i < mGot.size(); i++) begin
                            word[39-10*i -: 10] = mGot[i];
                        end
                        mBufData = word;
                        mBufVld  = 1'b1;
                        if (mCmd[2:0] == 3'd1) eWdone = 1'b1;
                    end
                end else if (mCmd[2:0] == 3'd1) begin
                    eWdone = 1'b1;
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic clearObs();
        seenVld  = 1'b0;
        seenData = '0;
        wdoneCnt = 0;
        protoCnt = 0;
        ovflCnt  = 0;
        tmoCnt   = 0;
    endtask

    // Drive one beat, then check the outputs one cycle later against the model.
    task automatic applyStimulus(input logic [9:0] beat, input bit rdy);
        wr_bus = beat;
        pw_rdy = rdy;
        modelStep(beat, rdy);
        @(posedge clk);
        #1;
        checkOutput("cycle", 64'({pw_vld, pw_data, wdone, err_proto, err_ovfl, err_timeout}),
                    64'({mBufVld, mBufData, eWdone, eProto, eOvfl, eTmo}));
        if (pw_vld) begin
            seenVld  = 1'b1;
            seenData = pw_data;
        end
        wdoneCnt += int'(wdone);
        protoCnt += int'(err_proto);
        ovflCnt  += int'(err_ovfl);
        tmoCnt   += int'(err_timeout);
    endtask

    initial begin
        logic [9:0] b;
        bit         r;
        int         p;
        int         stall;

        rst_n  = 1'b0;
        wr_bus = '0;
        pw_rdy = 1'b0;
        modelReset();
        clearObs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 64'({pw_vld, pw_data, wdone, err_proto, err_ovfl, err_timeout}), 64'd0);
        rst_n = 1'b1;

        // complete writes, applied with pw_rdy held high
        vecs[0] = '{cmd:10'h210, beats:{10'h1A1, 10'h2B2, 60'd0}, nb:2, expVld:1'b1,
                    expData:{10'h210, 10'h1A1, 10'h2B2, 20'd0}, expWdone:0, expProto:0};
        vecs[1] = '{cmd:10'h201, beats:{10'h111, 10'h000, 10'h122, 10'h000, 10'h133, 10'h000, 10'h244, 10'h000},
                    nb:7, expVld:1'b1, expData:{10'h201, 10'h111, 10'h122, 10'h133, 10'h244},
                    expWdone:4, expProto:0};
        vecs[2] = '{cmd:10'h20A, beats:{10'h2FF, 70'd0}, nb:1, expVld:1'b1,
                    expData:{10'h20A, 10'h2FF, 30'd0}, expWdone:1, expProto:0};
        vecs[3] = '{cmd:10'h218, beats:{10'h1AA, 10'h2BB, 60'd0}, nb:2, expVld:1'b0,
                    expData:50'd0, expWdone:0, expProto:1};
        vecs[4] = '{cmd:10'h218, beats:{10'h101, 10'h102, 10'h103, 50'd0}, nb:3, expVld:1'b0,
                    expData:50'd0, expWdone:0, expProto:1};
        vecs[5] = '{cmd:10'h205, beats:80'd0, nb:0, expVld:1'b0,
                    expData:50'd0, expWdone:0, expProto:1};
        vecs[6] = '{cmd:10'h208, beats:{10'h2C3, 70'd0}, nb:1, expVld:1'b1,
                    expData:{10'h208, 10'h2C3, 30'd0}, expWdone:0, expProto:0};
        vecs[7] = '{cmd:10'h208, beats:{10'h3FF, 70'd0}, nb:1, expVld:1'b0,
                    expData:50'd0, expWdone:0, expProto:1};
        vecs[8] = '{cmd:10'h3E8, beats:{10'h255, 70'd0}, nb:1, expVld:1'b1,
                    expData:{10'h3E8, 10'h255, 30'd0}, expWdone:0, expProto:0};

        for (int v = 0; v < 9; v++) begin
            clearObs();
            applyStimulus(vecs[v].cmd, 1'b1);
            for (int j = 0; j < vecs[v].nb; j++) begin
                applyStimulus(vecs[v].beats[j], 1'b1);
            end
            repeat (3) applyStimulus(10'h000, 1'b1);
            checkOutput($sformatf("v%0d_vld", v), 64'(seenVld), 64'(vecs[v].expVld));
            checkOutput($sformatf("v%0d_data", v), 64'(seenData), 64'(vecs[v].expData));
            checkOutput($sformatf("v%0d_wdone", v), 64'(wdoneCnt), 64'(vecs[v].expWdone));
            checkOutput($sformatf("v%0d_proto", v), 64'(protoCnt), 64'(vecs[v].expProto));
            checkOutput($sformatf("v%0d_tmo", v), 64'(tmoCnt), 64'd0);
        end

        // SINGLE_WDONE held under backpressure for 5 cycles
        clearObs();
        applyStimulus(10'h20A, 1'b0);
        applyStimulus(10'h2EE, 1'b0);
        checkOutput("bp_vld", 64'(pw_vld), 64'd1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(10'h000, 1'b0);
            checkOutput("bp_hold", 64'({pw_vld, pw_data}), 64'({1'b1, 10'h20A, 10'h2EE, 30'd0}));
        end
        checkOutput("bp_wdone_early", 64'(wdoneCnt), 64'd0);
        applyStimulus(10'h000, 1'b1);
        checkOutput("bp_pop", 64'(pw_vld), 64'd0);
        checkOutput("bp_wdone", 64'(wdone), 64'd1);
        applyStimulus(10'h000, 1'b1);
        checkOutput("bp_wdone_once", 64'(wdone), 64'd0);

        // overflow: second back-to-back write while the buffer is blocked
        applyStimulus(10'h208, 1'b0);
        applyStimulus(10'h211, 1'b0);
        applyStimulus(10'h208, 1'b0);
        applyStimulus(10'h222, 1'b0);
        checkOutput("ovfl_pulse", 64'(err_ovfl), 64'd1);
        checkOutput("ovfl_keep", 64'({pw_vld, pw_data}), 64'({1'b1, 10'h208, 10'h211, 30'd0}));
        applyStimulus(10'h000, 1'b0);
        checkOutput("ovfl_1cyc", 64'(err_ovfl), 64'd0);
        // simultaneous pop and load
        applyStimulus(10'h208, 1'b0);
        applyStimulus(10'h233, 1'b1);
        checkOutput("popload_noerr", 64'(err_ovfl), 64'd0);
        checkOutput("popload_data", 64'({pw_vld, pw_data}), 64'({1'b1, 10'h208, 10'h233, 30'd0}));
        repeat (2) applyStimulus(10'h000, 1'b1);

        // stall timeout after 16 consecutive IDLE beats
        clearObs();
        applyStimulus(10'h210, 1'b1);
        repeat (15) applyStimulus(10'h000, 1'b1);
        checkOutput("tmo_early", 64'(tmoCnt), 64'd0);
        applyStimulus(10'h000, 1'b1);
        checkOutput("tmo_pulse", 64'(err_timeout), 64'd1);
        applyStimulus(10'h208, 1'b1);
        applyStimulus(10'h277, 1'b1);
        checkOutput("tmo_recover", 64'({pw_vld, pw_data}), 64'({1'b1, 10'h208, 10'h277, 30'd0}));
        applyStimulus(10'h000, 1'b1);

        // reset in the middle of a write, with a write already buffered
        applyStimulus(10'h208, 1'b0);
        applyStimulus(10'h2AB, 1'b0);
        applyStimulus(10'h218, 1'b0);
        applyStimulus(10'h101, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", 64'({pw_vld, pw_data, wdone, err_proto, err_ovfl, err_timeout}), 64'd0);
        modelReset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clearObs();
        applyStimulus(10'h101, 1'b1);
        repeat (4) applyStimulus(10'h000, 1'b1);
        checkOutput("rst_quiet", 64'(protoCnt + ovflCnt + tmoCnt + wdoneCnt + int'(seenVld)), 64'd0);
        applyStimulus(10'h208, 1'b1);
        applyStimulus(10'h2CD, 1'b1);
        checkOutput("rst_recover", 64'({pw_vld, pw_data}), 64'({1'b1, 10'h208, 10'h2CD, 30'd0}));

        // randomized traffic, steered by the model's view of the protocol
        stall = 0;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 3) != 0);
            if (stall > 0) begin
                b = 10'h000;
                stall--;
            end else if (!mBusy) begin
                b = 10'($urandom);
                if ($urandom_range(0, 9) < 6) begin
                    b[9] = 1'b1;
                    if ($urandom_range(0, 7) != 0) b[2:0] = 3'($urandom_range(0, 2));
                end else begin
                    b[9] = 1'b0;
                end
            end else begin
                p = $urandom_range(0, 99);
                if (p < 2) begin
                    b     = 10'h000;
                    stall = 15 + $urandom_range(0, 1);
                end else if (p < 25) begin
                    b = 10'h000;
                end else if (p < 30) begin
                    b = 10'($urandom);
                end else begin
                    b = {2'b01, 8'($urandom)};
                    if (mGot.size() == mExp - 1) b[9:8] = 2'b10;
                end
            end
            applyStimulus(b, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
